// File: rtl/majority_decoder_if.sv
// Result bus of the redundant-circuit voter: replica words in, voted word and health flags out.
interface majority_decoder_if #(
    parameter int N     = 10,
    parameter int R     = 3,
    parameter int CNT_W = 16
);
    logic             valid_i;
    logic [R*N-1:0]   copies_i;
    logic             clear_i;
    logic [N-1:0]     z_o;
    logic             valid_o;
    logic             disagree_o;
    logic [R-1:0]     mismatch_o;
    logic [R-1:0]     fault_o;
    logic [CNT_W-1:0] err_total_o;

    modport master (
        output valid_i, copies_i, clear_i,
        input  z_o, valid_o, disagree_o, mismatch_o, fault_o, err_total_o
    );

    modport slave (
        input  valid_i, copies_i, clear_i,
        output z_o, valid_o, disagree_o, mismatch_o, fault_o, err_total_o
    );
endinterface

// File: rtl/majority_decoder.sv
// Bitwise majority voter over R replicas, 2-cycle latency, with per-replica
// saturating disagreement counters and sticky fault flags.
module majority_decoder_lane #(
    parameter int CNT_W        = 16,
    parameter int FAULT_THRESH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic fault
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(FAULT_THRESH - 1);

    logic [CNT_W-1:0] cnt;

    // clear wins over a same-edge increment; fault stays up through saturation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else if (inc && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
            if (cnt == THRESH_M1)
                fault <= 1'b1;
        end
    end
endmodule

module majority_decoder #(
    parameter int N            = 10,
    parameter int R            = 3,
    parameter int CNT_W        = 16,
    parameter int FAULT_THRESH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    majority_decoder_if.slave bus
);
    // vld_pipe[0] is the stage-1 valid, vld_pipe[STAGES] drives valid_o
    localparam int STAGES = 1;
    localparam int VW     = $clog2(R + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES:0]       vld_pipe;
    logic [R-1:0][N-1:0]   s1_copies;
    logic [N-1:0]          maj_c;
    logic [R-1:0]          mis_c;
    logic                  dis_c;
    logic [N-1:0]          z_q;
    logic [R-1:0]          mis_q;
    logic                  dis_q;
    logic [CNT_W-1:0]      err_q;
    logic [R-1:0]          fault;

    function automatic logic vote(input logic [R-1:0] col);
        logic [VW-1:0] ones;
        ones = '0;
        for (int r = 0; r < R; r++)
            ones = ones + VW'(col[r]);
        return ones > VW'(R / 2);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            s1_copies <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], bus.valid_i};
            s1_copies <= bus.copies_i;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_bit
        logic [R-1:0] col;
        for (genvar r = 0; r < R; r++) begin : g_col
            assign col[r] = s1_copies[r][j];
        end
        assign maj_c[j] = vote(col);
    end

    for (genvar r = 0; r < R; r++) begin : g_mis
        assign mis_c[r] = |(s1_copies[r] ^ maj_c);
    end
    assign dis_c = |mis_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_q   <= '0;
            mis_q <= '0;
            dis_q <= 1'b0;
        end else if (vld_pipe[0]) begin
            z_q   <= maj_c;
            mis_q <= mis_c;
            dis_q <= dis_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_q <= '0;
        else if (bus.clear_i)
            err_q <= '0;
        else if (vld_pipe[0] && dis_c && err_q != CNT_MAX)
            err_q <= err_q + 1'b1;
    end

    for (genvar r = 0; r < R; r++) begin : g_lane
        majority_decoder_lane #(
            .CNT_W        (CNT_W),
            .FAULT_THRESH (FAULT_THRESH)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (bus.clear_i),
            .inc     (vld_pipe[0] & mis_c[r]),
            .fault   (fault[r])
        );
    end

    assign bus.z_o         = z_q;
    assign bus.valid_o     = vld_pipe[STAGES];
    assign bus.mismatch_o  = mis_q;
    assign bus.disagree_o  = dis_q;
    assign bus.fault_o     = fault;
    assign bus.err_total_o = err_q;
endmodule

// File: doc/majority_decoder.md
Name: majority_decoder

Overview:
- Output decoder for the redundant circuit: takes R replicated N-bit result words, produces a bitwise-majority result and flags which replicas disagreed.
- Tracks per-replica disagreement counts and raises a sticky fault flag once a replica crosses a threshold.
- Sits between the replicated `circuit` instances and the consumer of z/valid; its output pair uses the same contract as `circuit` (z_o, valid_o).

Parameters:
- N, 10, result word width in bits.
- R, 3, replica count; odd, >= 3.
- CNT_W, 16, width of every disagreement counter.
- FAULT_THRESH, 8, per-replica count at which fault_o[r] sets; 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- valid_i  in  1  copies_i holds a new result set this cycle.
- copies_i  in  R*N  replica r occupies bits [r*N +: N].
- clear_i  in  1  synchronous clear of all counters and fault flags.
- z_o  out  N  bitwise majority of the R replicas.
- valid_o  out  1  z_o/mismatch_o/disagree_o are valid this cycle.
- disagree_o  out  1  at least one replica differed from z_o.
- mismatch_o  out  R  bit r set when replica r differed from z_o in any bit.
- fault_o  out  R  sticky: replica r count reached FAULT_THRESH.
- err_total_o  out  CNT_W  number of valid outputs with disagree_o=1.

Behaviour:
- Reset (async assert, sync release) clears all registers to 0: z_o, valid_o, disagree_o, mismatch_o, fault_o, err_total_o and internal counters. In-flight data is discarded.
- Pipeline is 2 stages, with a fixed latency of 2 cycles from valid_i to valid_o. No backpressure; accepts one set per cycle, so throughput is 1.
- Stage 1 registers copies_i and valid_i unconditionally.
- Stage 2 computes, when the stage-1 valid is set:
  - bit j of the result is 1 iff more than R/2 replicas have bit j = 1;
  - mismatch[r] = OR over bits of (replica r XOR majority);
  - disagree = OR over mismatch.
- Stage 2 registers z_o, mismatch_o and disagree_o; valid_o follows the stage-1 valid.
- When the stage-1 valid is 0: valid_o=0; z_o, mismatch_o and disagree_o hold their previous values; no counter changes.
- Per-replica counter cnt[r] increments by 1 on each valid set with mismatch[r]=1. err_total increments on each valid set with disagree=1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- fault_o[r] sets on the same edge that cnt[r] reaches FAULT_THRESH. It stays set until clear_i or reset, even if cnt[r] saturates.
- clear_i=1 zeroes all cnt[r], err_total_o and fault_o on the next edge. Clear has priority over a simultaneous increment: the result is 0, not 1.
- clear_i does not affect the data pipeline (z_o, valid_o, mismatch_o, disagree_o).
- Counters and fault_o update on the same edge that valid_o rises for the corresponding set.
- All replicas equal: mismatch_o=0, disagree_o=0, z_o equals the common value.
- With R=3, a single faulty replica is always outvoted. With two faulty replicas, the majority may be wrong. That case is not detectable and gets no special handling.

Test Plan:
- Reset then idle: reset_n low for 10 cycles, valid_i=0 -> all outputs 0 throughout and after release.
- Unanimous, N=10, R=3: copies = 0x155, 0x155, 0x155 with valid_i pulsed at cycle t -> valid_o=1 at t+2, z_o=0x155, mismatch_o=000, disagree_o=0, err_total_o=0.
- Single-bit fault: copies = 0x155, 0x154, 0x155 -> z_o=0x155, mismatch_o=010, disagree_o=1, err_total_o=1.
- Bitwise vote across replicas: copies = 0x3FF, 0x000, 0x00F -> z_o=0x00F, mismatch_o=011.
- Fault threshold: 8 back-to-back sets with replica 2 wrong -> fault_o=100 on the edge of the 8th valid_o; it stays set after 5 clean sets; then clear_i=1 coincident with a 9th faulty set -> counters=0, fault_o=000.
- Saturation and async reset: with CNT_W=4, 20 faulty sets -> err_total_o holds at 15. Then assert reset_n mid-burst (between edges) -> outputs go to 0 immediately, and the first set issued after release appears 2 cycles later with correct values.
